// File: rtl/sw_input_if.sv
// ============================================================================
//  Module      : sw_input_if
//  Description : Peripheral-bus read port of the switch/button input block.
//                The CPU load path (master) issues a one-cycle read strobe
//                with a word address; the peripheral (slave) answers one
//                cycle later with registered data and a valid pulse.
//  Signals     : sw_re     - read strobe, one cycle per read (master -> slave)
//                sw_addr   - word select, sampled with sw_re (master -> slave)
//                sw_rdata  - registered read data (slave -> master)
//                sw_rvalid - sw_rdata holds the previous-cycle read result
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sw_input_if;
   logic        sw_re;
   logic [1:0]  sw_addr;
   logic [31:0] sw_rdata;
   logic        sw_rvalid;

   modport master (output sw_re, output sw_addr, input sw_rdata, input sw_rvalid);
   modport slave  (input sw_re, input sw_addr, output sw_rdata, output sw_rvalid);
endinterface

`default_nettype wire

// File: rtl/sw_input.sv
// ============================================================================
//  Module      : sw_input
//  Description : Memory-mapped input peripheral. Synchronizes and debounces
//                board switches and push-buttons, latches sticky button-press
//                events and returns them through a registered read port.
//  Ports       : sw_clk   - system clock, all logic on its rising edge
//                sw_rst_n - asynchronous active-low reset
//                sw_in    - raw switch levels (asynchronous, active-high)
//                btn_in   - raw button levels (asynchronous, active-high)
//                bus      - read port (sw_re, sw_addr, sw_rdata, sw_rvalid)
//  Read map    : 0 = debounced switches, 1 = debounced buttons,
//                2 = press events (read clears), 3 = zero
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_input #(
   parameter int SW_WIDTH        = 24,
   parameter int BTN_WIDTH       = 5,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  wire logic                 sw_clk,
   input  wire logic                 sw_rst_n,
   input  wire logic [SW_WIDTH-1:0]  sw_in,
   input  wire logic [BTN_WIDTH-1:0] btn_in,
   sw_input_if.slave                 bus
);

   // Counter only has to reach DEBOUNCE_CYCLES-1.
   localparam int                CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ADDR_SW  = 2'd0;
   localparam logic [1:0] ADDR_BTN = 2'd1;
   localparam logic [1:0] ADDR_EVT = 2'd2;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [SW_WIDTH-1:0]  sync1_sw_q,  sync1_sw_d;
   logic [SW_WIDTH-1:0]  sync2_sw_q,  sync2_sw_d;
   logic [SW_WIDTH-1:0]  sync3_sw_q,  sync3_sw_d;
   logic [BTN_WIDTH-1:0] sync1_btn_q, sync1_btn_d;
   logic [BTN_WIDTH-1:0] sync2_btn_q, sync2_btn_d;
   logic [BTN_WIDTH-1:0] sync3_btn_q, sync3_btn_d;

   logic [SW_WIDTH-1:0]  deb_sw_q,  deb_sw_d;
   logic [BTN_WIDTH-1:0] deb_btn_q, deb_btn_d;
   logic [CNT_W-1:0]     cnt_sw_q,  cnt_sw_d;
   logic [CNT_W-1:0]     cnt_btn_q, cnt_btn_d;

   logic [BTN_WIDTH-1:0] evt_q, evt_d;
   logic [31:0]          rdata_q, rdata_d;
   logic                 rvalid_q, rvalid_d;

   logic [BTN_WIDTH-1:0] btn_rise;
   logic                 evt_clr;

   // ------------------------------------------------------------------
   // Synchronizers: sync1/sync2 resolve metastability, sync3 keeps the
   // previous settled sample so a change can be spotted.
   // ------------------------------------------------------------------
   always_comb begin
      sync1_sw_d  = sw_in;
      sync2_sw_d  = sync1_sw_q;
      sync3_sw_d  = sync2_sw_q;
      sync1_btn_d = btn_in;
      sync2_btn_d = sync1_btn_q;
      sync3_btn_d = sync2_btn_q;
   end

   // ------------------------------------------------------------------
   // Switch-group debounce. A change in any bit restarts the count and
   // the debounced vector updates as a whole.
   // ------------------------------------------------------------------
   always_comb begin
      deb_sw_d = deb_sw_q;
      cnt_sw_d = cnt_sw_q;
      if (sync2_sw_q != sync3_sw_q) begin
         cnt_sw_d = '0;
      end else if (sync2_sw_q != deb_sw_q) begin
         if (cnt_sw_q == CNT_MAX) begin
            deb_sw_d = sync2_sw_q;
            cnt_sw_d = '0;
         end else begin
            cnt_sw_d = cnt_sw_q + 1'b1;
         end
      end else begin
         cnt_sw_d = '0;
      end
   end

   // ------------------------------------------------------------------
   // Button-group debounce, same rule with its own counter.
   // ------------------------------------------------------------------
   always_comb begin
      deb_btn_d = deb_btn_q;
      cnt_btn_d = cnt_btn_q;
      if (sync2_btn_q != sync3_btn_q) begin
         cnt_btn_d = '0;
      end else if (sync2_btn_q != deb_btn_q) begin
         if (cnt_btn_q == CNT_MAX) begin
            deb_btn_d = sync2_btn_q;
            cnt_btn_d = '0;
         end else begin
            cnt_btn_d = cnt_btn_q + 1'b1;
         end
      end else begin
         cnt_btn_d = '0;
      end
   end

   // ------------------------------------------------------------------
   // Press events. A rise is detected on the value being loaded this
   // edge, so the event bit appears together with the debounced level.
   // An event read clears old bits but lets same-edge rises through.
   // ------------------------------------------------------------------
   always_comb begin
      btn_rise = deb_btn_d & ~deb_btn_q;
      evt_clr  = bus.sw_re && (bus.sw_addr == ADDR_EVT);
      evt_d    = (evt_clr ? '0 : evt_q) | btn_rise;
   end

   // ------------------------------------------------------------------
   // Read port: data captured from pre-edge register state, so an event
   // read returns the value before its own clear.
   // ------------------------------------------------------------------
   always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = bus.sw_re;
      if (bus.sw_re) begin
         case (bus.sw_addr)
            ADDR_SW:  rdata_d = 32'(deb_sw_q);
            ADDR_BTN: rdata_d = 32'(deb_btn_q);
            ADDR_EVT: rdata_d = 32'(evt_q);
            default:  rdata_d = 32'h0;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge sw_clk or negedge sw_rst_n) begin
      if (!sw_rst_n) begin
         sync1_sw_q  <= '0;
         sync2_sw_q  <= '0;
         sync3_sw_q  <= '0;
         sync1_btn_q <= '0;
         sync2_btn_q <= '0;
         sync3_btn_q <= '0;
         deb_sw_q    <= '0;
         deb_btn_q   <= '0;
         cnt_sw_q    <= '0;
         cnt_btn_q   <= '0;
         evt_q       <= '0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
      end else begin
         sync1_sw_q  <= sync1_sw_d;
         sync2_sw_q  <= sync2_sw_d;
         sync3_sw_q  <= sync3_sw_d;
         sync1_btn_q <= sync1_btn_d;
         sync2_btn_q <= sync2_btn_d;
         sync3_btn_q <= sync3_btn_d;
         deb_sw_q    <= deb_sw_d;
         deb_btn_q   <= deb_btn_d;
         cnt_sw_q    <= cnt_sw_d;
         cnt_btn_q   <= cnt_btn_d;
         evt_q       <= evt_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
      end
   end

   assign bus.sw_rdata  = rdata_q;
   assign bus.sw_rvalid = rvalid_q;

endmodule

`default_nettype wire

// File: doc/sw_input.md
# sw_input

Memory-mapped input peripheral: the read-side counterpart to the LED output register. Samples 24 board switches and 5 push-buttons, synchronizes and debounces them, latches button-press events, and returns them to the CPU load path through a registered read port. Sits on the pipeline's peripheral bus beside the LED display register.

## Interface
- SW_WIDTH, 24, number of switch inputs.
- BTN_WIDTH, 5, number of button inputs.
- DEBOUNCE_CYCLES, 16, stable cycles required before a debounced value updates. Use 16 in simulation; the board build overrides it. Minimum is 2.
- sw_clk  in  1  system clock; all logic on its rising edge.
- sw_rst_n  in  1  asynchronous, active-low reset.
- sw_in  in  SW_WIDTH  raw switch levels, asynchronous, active-high.
- btn_in  in  BTN_WIDTH  raw button levels, asynchronous, active-high.
- sw_re  in  1  read strobe, one cycle per read.
- sw_addr  in  2  word select, sampled with sw_re.
- sw_rdata  out  32  registered read data.
- sw_rvalid  out  1  one-cycle pulse: sw_rdata holds the result of the previous-cycle read.

## Operation
- Synchronizer: two flops per input bit, sync1 then sync2. A third flop, sync3, holds the previous sync2 value.
- Debounce is per group. The switch vector and the button vector each have their own counter, width clog2(DEBOUNCE_CYCLES). Per group, each edge:
  - sync2 != sync3: cnt <= 0.
  - else if sync2 != deb and cnt == DEBOUNCE_CYCLES-1: deb <= sync2; cnt <= 0.
  - else if sync2 != deb: cnt <= cnt+1.
  - else: cnt <= 0.
- Any glitch in any bit restarts its group's count. The whole vector updates atomically.
- Press events: evt[i] <= 1 on a 0->1 transition of deb_btn[i]. The bit is sticky until cleared by a read of address 2.
- Read map, zero-extended to 32 bits:
  - 0: deb_sw.
  - 1: deb_btn.
  - 2: evt. This read clears evt.
  - 3: 32'h0.
- Simultaneous event set and address-2 read: sw_rdata returns the pre-clear evt. Bits newly set in that cycle survive the clear; all other bits clear.
- sw_re low: sw_rdata holds its last value; sw_rvalid = 0.
- Back-to-back reads: each cycle with sw_re = 1 produces one result in the next cycle. No stalls.

## Timing
- Reset values: all sync flops, deb_sw, deb_btn, both counters, evt, sw_rdata = 0; sw_rvalid = 0.
- Input-to-debounced latency: counting the first edge that samples a new stable value as edge 1, deb changes at edge DEBOUNCE_CYCLES+3. With the default, that is edge 19.
- Event latency: evt bit visible at the same edge deb_btn rises.
- Read latency: sw_re at edge k produces sw_rdata/sw_rvalid valid after edge k+1. The read sees register state from before edge k.
- Reset asserted mid-debounce or mid-read: everything clears immediately; no pending rvalid. After release, debounce restarts from deb = 0, so a held input appears after DEBOUNCE_CYCLES+3 edges.
- A button pressed across reset release produces an event, because deb goes 0->1 after release.
- An input pulse shorter than DEBOUNCE_CYCLES+1 stable cycles never changes deb.

## Test plan
- Reset: hold sw_rst_n = 0 with sw_in = 24'hABCDEF. Required: sw_rdata = 0, sw_rvalid = 0. Release; read addr 0 at edge 20+. Required: sw_rdata = 32'h00ABCDEF, and a read at edge 18 returns 0.
- Bounce: toggle sw_in[0] every 5 cycles for 60 cycles, then hold at 1. Required: deb_sw[0] changes exactly once, at edge 19 after the final change.
- Button event: press btn_in[2] for 40 cycles. Required: addr-2 read returns 32'h4; an immediate second read returns 0; an addr-1 read during the press returns 32'h4.
- Set/clear race: schedule an addr-2 read at the exact edge deb_btn[0] rises, with evt = 5'b00010 beforehand. Required: read returns 32'h2; next addr-2 read returns 32'h1.
- Back-to-back reads: addresses 0, 1, 2, 3 on consecutive cycles. Required: sw_rvalid high 4 consecutive cycles with the matching data; addr 3 = 0.
- Mid-operation reset: assert reset during a debounce count and during an sw_re cycle. Required: no rvalid pulse; all outputs 0 within the reset assertion.
